// File: rtl/mem_arb_pkg.sv
// Shared types for the instruction/data memory port arbiter.
package mem_arb_pkg;

    // Bus and MEM-stage command encoding; 2'b11 is never driven and reads as no request.
    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } mem_cmd_e;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        RESP  = 2'b10
    } arb_state_e;

    typedef enum logic [1:0] {
        OWN_NONE = 2'b00,
        OWN_IF   = 2'b01,
        OWN_DMEM = 2'b10
    } owner_e;

    // True only for the two real data commands.
    function automatic logic is_mem_op(input logic [1:0] cmd);
        return (cmd == MEM_LOAD) || (cmd == MEM_STORE);
    endfunction

endpackage

// File: rtl/imem_dmem_arbiter.sv
// Arbiter for the single unified memory port shared by instruction fetch and
// the MEM-stage load/store unit. Data accesses have fixed priority; a
// starvation counter hands the port to fetch after STARVE_LIMIT consecutive
// data grants made while fetch was waiting. One transaction is outstanding.
//
// Handshakes: a requester raises its request (if_req / dmem_cmd) with stable
// address/data and holds it until its completion pulse (if_rvalid /
// dmem_done); the stall outputs are the request gated by that pulse. On the
// bus, mem_cmd/mem_addr/mem_wdata are held until the cycle mem_gnt is high;
// read data comes back later as a one-cycle mem_rvalid.
// dbg_state exposes the FSM state for observation.
module imem_dmem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int XLEN         = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            if_req,
    input  logic [XLEN-1:0] if_addr,
    input  logic            if_flush,
    output logic            if_stall,
    output logic            if_rvalid,
    output logic [XLEN-1:0] if_rdata,
    input  logic [1:0]      dmem_cmd,
    input  logic [XLEN-1:0] dmem_addr,
    input  logic [XLEN-1:0] dmem_wdata,
    output logic            dmem_stall,
    output logic            dmem_done,
    output logic [XLEN-1:0] dmem_rdata,
    output logic [1:0]      mem_cmd,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic            mem_gnt,
    input  logic            mem_rvalid,
    input  logic [XLEN-1:0] mem_rdata,
    output logic [1:0]      dbg_state
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [XLEN-1:0] WORD_MASK = ~XLEN'(3);

    arb_state_e       state;
    owner_e           owner;
    logic [CNT_W-1:0] starve_cnt;
    logic             flush_pend;

    logic dmem_valid;
    logic starve_hit;
    logic grant_d;
    logic grant_if;
    logic issue_gnt;
    logic resp_done;

    // Arbitration: data first unless fetch has waited through STARVE_LIMIT data grants.
    assign dmem_valid = is_mem_op(dmem_cmd);
    assign starve_hit = if_req && (starve_cnt == CNT_W'(STARVE_LIMIT));
    assign grant_d    = dmem_valid && !starve_hit;
    assign grant_if   = !grant_d && if_req;

    // Completion events; responses are routed combinationally in their cycle.
    assign issue_gnt  = (state == ISSUE) && mem_gnt;
    assign resp_done  = (state == RESP) && mem_rvalid;

    assign dmem_done  = (issue_gnt && (mem_cmd == MEM_STORE)) ||
                        (resp_done && (owner == OWN_DMEM));
    assign if_rvalid  = resp_done && (owner == OWN_IF) && !flush_pend && !if_flush;
    assign dmem_rdata = mem_rdata;
    assign if_rdata   = mem_rdata;

    assign if_stall   = if_req & ~if_rvalid;
    assign dmem_stall = dmem_valid & ~dmem_done;
    assign dbg_state  = state;

    // Arbiter FSM with registered bus command, owner, starvation count and flush tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_NONE;
            starve_cnt <= '0;
            flush_pend <= 1'b0;
            mem_cmd    <= MEM_NONE;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    flush_pend <= 1'b0;
                    if (grant_d) begin
                        mem_cmd   <= dmem_cmd;
                        mem_addr  <= dmem_addr & WORD_MASK;
                        mem_wdata <= dmem_wdata;
                        owner     <= OWN_DMEM;
                        state     <= ISSUE;
                    end else if (grant_if && !if_flush) begin
                        // A fetch granted during a flush is dropped before it reaches the bus.
                        mem_cmd   <= MEM_LOAD;
                        mem_addr  <= if_addr & WORD_MASK;
                        mem_wdata <= '0;
                        owner     <= OWN_IF;
                        state     <= ISSUE;
                    end
                    if (grant_d && if_req) begin
                        if (starve_cnt != CNT_W'(STARVE_LIMIT)) begin
                            starve_cnt <= starve_cnt + CNT_W'(1);
                        end
                    end else begin
                        starve_cnt <= '0;
                    end
                end
                ISSUE: begin
                    if (owner == OWN_IF && if_flush) begin
                        flush_pend <= 1'b1;
                    end
                    if (mem_gnt) begin
                        mem_cmd <= MEM_NONE;
                        if (mem_cmd == MEM_STORE) begin
                            owner <= OWN_NONE;
                            state <= IDLE;
                        end else begin
                            state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (mem_rvalid) begin
                        owner      <= OWN_NONE;
                        flush_pend <= 1'b0;
                        state      <= IDLE;
                    end else if (owner == OWN_IF && if_flush) begin
                        flush_pend <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
